// File: rtl/pong_round_scheduler_if.sv
// Handshake bundle between the pong round scheduler and the video/ball/paddle blocks.
// master drives frame timing, button and geometry; slave is the scheduler.
interface pong_round_scheduler_if #(
  parameter int XBITS = 10,
  parameter int YBITS = 9
);
  logic                    frameTick;
  logic                    serveBtn;
  logic signed [YBITS:0]   ballTop;
  logic signed [YBITS:0]   ballBottom;
  logic signed [XBITS:0]   ballLeft;
  logic signed [XBITS:0]   ballRight;
  logic signed [YBITS:0]   paddleLTop;
  logic signed [YBITS:0]   paddleRTop;
  logic                    ballMove;
  logic                    ballReset;
  logic                    paddleMove;
  logic [3:0]              scoreL;
  logic [3:0]              scoreR;
  logic [2:0]              state;

  modport master (
    output frameTick, serveBtn, ballTop, ballBottom, ballLeft, ballRight,
           paddleLTop, paddleRTop,
    input  ballMove, ballReset, paddleMove, scoreL, scoreR, state
  );

  modport slave (
    input  frameTick, serveBtn, ballTop, ballBottom, ballLeft, ballRight,
           paddleLTop, paddleRTop,
    output ballMove, ballReset, paddleMove, scoreL, scoreR, state
  );
endinterface

// File: rtl/pong_round_scheduler.sv
// Pong round sequencer: IDLE->SERVE->PLAY->POINT->OVER, scoring and ball/paddle strobes.
// Optional ball speed-up on repeated paddle hits is enabled by defining PONG_SPEEDUP_EN.
module pong_round_scheduler #(
  parameter int WIDTH            = 640,
  parameter int HEIGHT           = 480,
  parameter int PADDLE_H         = 32,
  parameter int SERVE_FRAMES     = 60,
  parameter int POINT_FRAMES     = 90,
  parameter int WIN_SCORE        = 9,
  parameter int START_DIV        = 4,
  parameter int HITS_PER_SPEEDUP = 4,
  parameter int XBITS            = 10,
  parameter int YBITS            = 9
) (
  input  logic                        clk,
  input  logic                        resetN,
  pong_round_scheduler_if.slave       bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam int PHASE_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W     = $clog2(PHASE_MAX + 1);
  localparam int DIV_W     = $clog2(START_DIV + 1);

  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] POINT_LOAD = CNT_W'(POINT_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [DIV_W-1:0] DIV_START  = DIV_W'(START_DIV);
  localparam logic [DIV_W-1:0] DIV_UNIT   = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO   = DIV_W'(0);
  localparam logic [3:0]       WIN_C      = 4'(WIN_SCORE);
  localparam logic [3:0]       SCORE_ONE  = 4'd1;

  localparam logic signed [XBITS:0]   LEFT_WALL   = (XBITS + 1)'(0);
  localparam logic signed [XBITS:0]   RIGHT_WALL  = (XBITS + 1)'(WIDTH - 1);
  localparam logic signed [YBITS+1:0] PADDLE_SPAN = (YBITS + 2)'(PADDLE_H - 1);

`ifdef PONG_SPEEDUP_EN
  localparam int               HIT_W    = $clog2(HITS_PER_SPEEDUP + 1);
  localparam logic [HIT_W-1:0] HIT_LAST = HIT_W'(HITS_PER_SPEEDUP - 1);
  localparam logic [HIT_W-1:0] HIT_ZERO = HIT_W'(0);
  localparam logic [HIT_W-1:0] HIT_ONE  = HIT_W'(1);
  logic [HIT_W-1:0] hit_cnt_r;
`endif

  // Parameter sanity: a score above 15 or a paddle taller than the field cannot work.
  if (WIN_SCORE > 15 || WIN_SCORE < 1 || HEIGHT < PADDLE_H || START_DIV < 1 ||
      HITS_PER_SPEEDUP < 1 || SERVE_FRAMES < 1 || POINT_FRAMES < 1) begin : g_param_check
    $error("pong_round_scheduler: illegal parameter combination");
  end

  logic [2:0]       state_r;
  logic [3:0]       score_l_r;
  logic [3:0]       score_r_r;
  logic [CNT_W-1:0] phase_cnt_r;
  logic [DIV_W-1:0] frame_cnt_r;
  logic [DIV_W-1:0] div_r;
  logic             ball_move_r;
  logic             ball_reset_r;
  logic             paddle_move_r;

  // One extra bit on the vertical terms so paddle bottom never wraps near the field edge.
  logic signed [YBITS+1:0] ball_top_s, ball_bot_s;
  logic signed [YBITS+1:0] pad_l_top_s, pad_l_bot_s, pad_r_top_s, pad_r_bot_s;
  logic left_wall_s, right_wall_s, ovl_l_s, ovl_r_s;
  logic left_miss_s, right_miss_s, miss_any_s, hit_s, win_s, serve_go_s;

  assign ball_top_s   = {bus.ballTop[YBITS], bus.ballTop};
  assign ball_bot_s   = {bus.ballBottom[YBITS], bus.ballBottom};
  assign pad_l_top_s  = {bus.paddleLTop[YBITS], bus.paddleLTop};
  assign pad_r_top_s  = {bus.paddleRTop[YBITS], bus.paddleRTop};
  assign pad_l_bot_s  = pad_l_top_s + PADDLE_SPAN;
  assign pad_r_bot_s  = pad_r_top_s + PADDLE_SPAN;

  assign left_wall_s  = (bus.ballLeft <= LEFT_WALL);
  assign right_wall_s = (bus.ballRight >= RIGHT_WALL);
  assign ovl_l_s      = (ball_bot_s >= pad_l_top_s) && (ball_top_s <= pad_l_bot_s);
  assign ovl_r_s      = (ball_bot_s >= pad_r_top_s) && (ball_top_s <= pad_r_bot_s);
  assign left_miss_s  = left_wall_s & ~ovl_l_s;
  assign right_miss_s = right_wall_s & ~ovl_r_s;
  assign miss_any_s   = left_miss_s | right_miss_s;
  assign hit_s        = (left_wall_s & ovl_l_s) | (right_wall_s & ovl_r_s);
  assign win_s        = (score_l_r == WIN_C) || (score_r_r == WIN_C);

  // Every entry into SERVE recentres the ball and restores the starting speed.
  assign serve_go_s = bus.frameTick &
                      ((((state_r == S_IDLE) || (state_r == S_OVER)) & bus.serveBtn) |
                       ((state_r == S_POINT) & (phase_cnt_r == CNT_ZERO) & ~win_s));

  // Round state machine, scoring and registered strobes.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r       <= S_IDLE;
      score_l_r     <= 4'd0;
      score_r_r     <= 4'd0;
      phase_cnt_r   <= CNT_ZERO;
      frame_cnt_r   <= DIV_ZERO;
      div_r         <= DIV_START;
      ball_move_r   <= 1'b0;
      ball_reset_r  <= 1'b0;
      paddle_move_r <= 1'b0;
`ifdef PONG_SPEEDUP_EN
      hit_cnt_r     <= HIT_ZERO;
`endif
    end else begin
      ball_move_r   <= 1'b0;
      ball_reset_r  <= 1'b0;
      paddle_move_r <= 1'b0;
      if (bus.frameTick) begin
        case (state_r)
          S_IDLE: begin
            if (bus.serveBtn) state_r <= S_SERVE;
            else              state_r <= S_IDLE;
          end
          S_SERVE: begin
            paddle_move_r <= 1'b1;
            if (phase_cnt_r == CNT_ZERO) begin
              state_r     <= S_PLAY;
              frame_cnt_r <= DIV_ZERO;
            end else begin
              phase_cnt_r <= phase_cnt_r - CNT_ONE;
            end
          end
          S_PLAY: begin
            paddle_move_r <= 1'b1;
            if (miss_any_s) begin
              // A double miss awards nobody; a single miss scores for the other side.
              state_r     <= S_POINT;
              phase_cnt_r <= POINT_LOAD;
              frame_cnt_r <= DIV_ZERO;
              if (left_miss_s && !right_miss_s && score_r_r != WIN_C)
                score_r_r <= score_r_r + SCORE_ONE;
              else if (right_miss_s && !left_miss_s && score_l_r != WIN_C)
                score_l_r <= score_l_r + SCORE_ONE;
              else
                score_l_r <= score_l_r;
            end else if (frame_cnt_r >= div_r - DIV_UNIT) begin
              ball_move_r <= 1'b1;
              frame_cnt_r <= DIV_ZERO;
            end else begin
              frame_cnt_r <= frame_cnt_r + DIV_UNIT;
            end
`ifdef PONG_SPEEDUP_EN
            if (hit_s) begin
              if (hit_cnt_r == HIT_LAST) begin
                hit_cnt_r <= HIT_ZERO;
                if (div_r > DIV_UNIT) div_r <= div_r - DIV_UNIT;
                else                  div_r <= div_r;
              end else begin
                hit_cnt_r <= hit_cnt_r + HIT_ONE;
              end
            end else begin
              hit_cnt_r <= hit_cnt_r;
            end
`endif
          end
          S_POINT: begin
            if (phase_cnt_r == CNT_ZERO) begin
              if (win_s) state_r <= S_OVER;
              else       state_r <= S_SERVE;
            end else begin
              phase_cnt_r <= phase_cnt_r - CNT_ONE;
            end
          end
          S_OVER: begin
            if (bus.serveBtn) begin
              state_r   <= S_SERVE;
              score_l_r <= 4'd0;
              score_r_r <= 4'd0;
            end else begin
              state_r <= S_OVER;
            end
          end
          default: state_r <= S_IDLE;
        endcase
        if (serve_go_s) begin
          ball_reset_r <= 1'b1;
          phase_cnt_r  <= SERVE_LOAD;
          div_r        <= DIV_START;
`ifdef PONG_SPEEDUP_EN
          hit_cnt_r    <= HIT_ZERO;
`endif
        end
      end
    end
  end

  // hit_s only steers the speed-up counter; without it a hit simply avoids a miss.
  logic unused_hit_s;
  assign unused_hit_s = hit_s;

  assign bus.ballMove   = ball_move_r;
  assign bus.ballReset  = ball_reset_r;
  assign bus.paddleMove = paddle_move_r;
  assign bus.scoreL     = score_l_r;
  assign bus.scoreR     = score_r_r;
  assign bus.state      = state_r;

endmodule
